// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the writeback stage: status codes, register IDs,
// icodes and the W pipeline register layout.
package y86_pkg;

  localparam int Y86_DATA_W = 64;
  localparam int Y86_REG_W  = 4;
  localparam int Y86_STAT_W = 3;

  localparam logic [Y86_STAT_W-1:0] SAOK = 3'd1;
  localparam logic [Y86_STAT_W-1:0] SHLT = 3'd2;
  localparam logic [Y86_STAT_W-1:0] SADR = 3'd3;
  localparam logic [Y86_STAT_W-1:0] SINS = 3'd4;

  localparam logic [Y86_REG_W-1:0] RNONE = 4'hF;

  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] INOP  = 4'h1;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [Y86_STAT_W-1:0] stat;
    logic [3:0]            icode;
    logic [Y86_DATA_W-1:0] val_e;
    logic [Y86_DATA_W-1:0] val_m;
    logic [Y86_REG_W-1:0]  dst_e;
    logic [Y86_REG_W-1:0]  dst_m;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{
    valid: 1'b0,
    stat:  SAOK,
    icode: INOP,
    val_e: '0,
    val_m: '0,
    dst_e: RNONE,
    dst_m: RNONE
  };

endpackage

// File: rtl/wb_retire_cnt.sv
// Retired-instruction counter for the writeback stage; wraps to zero on overflow.
module wb_retire_cnt #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/wb_stage.sv
// Y86-64 writeback stage: W pipeline register, register-array write-port gating and
// sticky halt FSM. Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
  import y86_pkg::*;
#(
  // Widths must match the y86_pkg W register layout.
  parameter int DATA_W = Y86_DATA_W,
  parameter int REG_W  = Y86_REG_W,
  parameter int STAT_W = Y86_STAT_W
`ifdef WB_RETIRE_CNT_EN
  ,
  parameter int CNT_W  = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_valid,
  input  logic [STAT_W-1:0] m_stat,
  input  logic [3:0]        m_icode,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [REG_W-1:0]  m_dstE,
  input  logic [REG_W-1:0]  m_dstM,
  input  logic              w_stall,
  input  logic              w_bubble,
  output logic [REG_W-1:0]  dstE,
  output logic [DATA_W-1:0] E,
  output logic [REG_W-1:0]  dstM,
  output logic [DATA_W-1:0] M,
  output logic [STAT_W-1:0] w_stat,
  output logic [3:0]        w_icode,
  output logic              halted
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retired
`endif
);

  w_reg_t    w_q;
  w_reg_t    w_d;
  wb_state_e state_q;
  wb_state_e state_d;

  logic [REG_W-1:0] dst_e_gated;
  logic [REG_W-1:0] dst_m_gated;
  logic             w_commit;

  always_comb begin
    w_d     = w_q;
    state_d = state_q;
    if (state_q == RUN && !w_stall) begin
      // An invalid M slot loads a clean bubble so it can never raise a fault.
      if (w_bubble || !m_valid) begin
        w_d = W_BUBBLE;
      end else begin
        w_d.valid = 1'b1;
        w_d.stat  = m_stat;
        w_d.icode = m_icode;
        w_d.val_e = m_valE;
        w_d.val_m = m_valM;
        w_d.dst_e = m_dstE;
        w_d.dst_m = m_dstM;
        if (m_stat != SAOK) begin
          state_d = HALTED;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q     <= W_BUBBLE;
      state_q <= RUN;
    end else begin
      w_q     <= w_d;
      state_q <= state_d;
    end
  end

  assign w_commit    = w_q.valid && (w_q.stat == SAOK);
  assign dst_e_gated = w_commit ? w_q.dst_e : RNONE;
  assign dst_m_gated = w_commit ? w_q.dst_m : RNONE;

  // Same destination on both ports: the memory result wins (popq %rsp).
  always_comb begin
    dstE = dst_e_gated;
    if (dst_e_gated == dst_m_gated && dst_m_gated != RNONE) begin
      dstE = RNONE;
    end
  end

  assign dstM    = dst_m_gated;
  assign E       = w_q.val_e;
  assign M       = w_q.val_m;
  assign w_stat  = w_q.stat;
  assign w_icode = w_q.icode;
  assign halted  = (state_q == HALTED);

`ifdef WB_RETIRE_CNT_EN
  logic retire_inc;

  assign retire_inc = (state_q == RUN) && !w_stall && !w_bubble &&
                      m_valid && (m_stat == SAOK);

  wb_retire_cnt #(
    .CNT_W(CNT_W)
  ) u_retire_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (retire_inc),
    .count(retired)
  );
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected W outputs, monitors pop and
// compare after each clock edge or asynchronous reset assertion.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        m_valid;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE;
  logic [63:0] m_valM;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;
  logic        w_stall;
  logic        w_bubble;
  logic [3:0]  dstE;
  logic [63:0] E;
  logic [3:0]  dstM;
  logic [63:0] M;
  logic [2:0]  w_stat;
  logic [3:0]  w_icode;
  logic        halted;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retired;
`endif

  wb_stage dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_valid (m_valid),
    .m_stat  (m_stat),
    .m_icode (m_icode),
    .m_valE  (m_valE),
    .m_valM  (m_valM),
    .m_dstE  (m_dstE),
    .m_dstM  (m_dstM),
    .w_stall (w_stall),
    .w_bubble(w_bubble),
    .dstE    (dstE),
    .E       (E),
    .dstM    (dstM),
    .M       (M),
    .w_stat  (w_stat),
    .w_icode (w_icode),
    .halted  (halted)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retired (retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  dst_e;
    logic [63:0] e;
    logic [3:0]  dst_m;
    logic [63:0] m;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        halt;
    logic [63:0] ret;
  } exp_t;

  exp_t clk_q[$];
  exp_t rst_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string txn, input string fld,
                     input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h required %h", txn, fld, act, req);
    end
  endtask

  task automatic compare(input exp_t x);
    chk(x.name, "dstE",    64'(dstE),    64'(x.dst_e));
    chk(x.name, "E",       E,            x.e);
    chk(x.name, "dstM",    64'(dstM),    64'(x.dst_m));
    chk(x.name, "M",       M,            x.m);
    chk(x.name, "w_stat",  64'(w_stat),  64'(x.stat));
    chk(x.name, "w_icode", 64'(w_icode), 64'(x.icode));
    chk(x.name, "halted",  64'(halted),  64'(x.halt));
`ifdef WB_RETIRE_CNT_EN
    chk(x.name, "retired", retired,      x.ret);
`endif
    $display("[%0t] txn %-10s dstE=%h E=%h dstM=%h M=%h stat=%0d icode=%h halted=%b",
             $time, x.name, dstE, E, dstM, M, w_stat, w_icode, halted);
  endtask

  always @(posedge clk) begin
    #1;
    if (clk_q.size() > 0) compare(clk_q.pop_front());
  end

  always @(negedge rst_n) begin
    #1;
    if (rst_q.size() > 0) compare(rst_q.pop_front());
  end

  task automatic drive(input logic v, input logic [2:0] st, input logic [3:0] ic,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic stl, input logic bub);
    m_valid  = v;
    m_stat   = st;
    m_icode  = ic;
    m_valE   = ve;
    m_valM   = vm;
    m_dstE   = de;
    m_dstM   = dm;
    w_stall  = stl;
    w_bubble = bub;
  endtask

  function automatic exp_t mk(input string nm, input logic [3:0] de, input logic [63:0] e,
                              input logic [3:0] dm, input logic [63:0] m,
                              input logic [2:0] st, input logic [3:0] ic,
                              input logic h, input logic [63:0] r);
    exp_t x;
    x.name = nm; x.dst_e = de; x.e = e; x.dst_m = dm; x.m = m;
    x.stat = st; x.icode = ic; x.halt = h; x.ret = r;
    return x;
  endfunction

  // One cycle of stimulus plus the outputs expected after the following rising edge.
  task automatic step(input string nm,
                      input logic v, input logic [2:0] st, input logic [3:0] ic,
                      input logic [63:0] ve, input logic [63:0] vm,
                      input logic [3:0] de, input logic [3:0] dm,
                      input logic stl, input logic bub,
                      input logic [3:0] x_de, input logic [63:0] x_e,
                      input logic [3:0] x_dm, input logic [63:0] x_m,
                      input logic [2:0] x_st, input logic [3:0] x_ic,
                      input logic x_h, input logic [63:0] x_r);
    @(negedge clk);
    drive(v, st, ic, ve, vm, de, dm, stl, bub);
    clk_q.push_back(mk(nm, x_de, x_e, x_dm, x_m, x_st, x_ic, x_h, x_r));
  endtask

  task automatic reset_now(input string nm);
    rst_q.push_back(mk(nm, 4'hF, 64'h0, 4'hF, 64'h0, 3'd1, 4'h1, 1'b0, 64'd0));
    rst_n = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 3'd1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 3'd1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b0);
    #2;
    reset_now("reset");
    release_reset();

    //    name          v  st    ic     valE           valM           dE    dM    stl   bub    | dstE  E              dstM  M             st    ic     h     ret
    step("load",       1, 3'd1, 4'h6, 64'h1234,      64'h0,         4'h3, 4'hF, 1'b0, 1'b0,  4'h3, 64'h1234,      4'hF, 64'h0,        3'd1, 4'h6, 1'b0, 64'd1);
    step("collide",    1, 3'd1, 4'hB, 64'h10,        64'h99,        4'h4, 4'h4, 1'b0, 1'b0,  4'hF, 64'h10,        4'h4, 64'h99,       3'd1, 4'hB, 1'b0, 64'd2);
    step("stall1",     1, 3'd1, 4'h6, 64'hAAAA,      64'hBBBB,      4'h7, 4'h8, 1'b1, 1'b0,  4'hF, 64'h10,        4'h4, 64'h99,       3'd1, 4'hB, 1'b0, 64'd2);
    step("stall2",     1, 3'd1, 4'h5, 64'hCCCC,      64'hDDDD,      4'h9, 4'hA, 1'b1, 1'b0,  4'hF, 64'h10,        4'h4, 64'h99,       3'd1, 4'hB, 1'b0, 64'd2);
    step("stall_bub",  1, 3'd1, 4'h6, 64'hEEEE,      64'h0,         4'h7, 4'hF, 1'b1, 1'b1,  4'hF, 64'h10,        4'h4, 64'h99,       3'd1, 4'hB, 1'b0, 64'd2);
    step("bubble",     1, 3'd1, 4'h6, 64'h1111,      64'h2222,      4'h8, 4'h9, 1'b0, 1'b1,  4'hF, 64'h0,         4'hF, 64'h0,        3'd1, 4'h1, 1'b0, 64'd2);
    step("invalid",    0, 3'd3, 4'h6, 64'h55,        64'h66,        4'h5, 4'h6, 1'b0, 1'b0,  4'hF, 64'h0,         4'hF, 64'h0,        3'd1, 4'h1, 1'b0, 64'd2);
    step("aok3",       1, 3'd1, 4'h6, 64'h77,        64'h0,         4'h0, 4'hF, 1'b0, 1'b0,  4'h0, 64'h77,        4'hF, 64'h0,        3'd1, 4'h6, 1'b0, 64'd3);
    step("mrmov",      1, 3'd1, 4'h5, 64'h20,        64'hBEEF,      4'hF, 4'h2, 1'b0, 1'b0,  4'hF, 64'h20,        4'h2, 64'hBEEF,     3'd1, 4'h5, 1'b0, 64'd4);
    step("aok5",       1, 3'd1, 4'h6, 64'h1,         64'h0,         4'h1, 4'hF, 1'b0, 1'b0,  4'h1, 64'h1,         4'hF, 64'h0,        3'd1, 4'h6, 1'b0, 64'd5);
    step("adr",        1, 3'd3, 4'h5, 64'h30,        64'h40,        4'h2, 4'hF, 1'b0, 1'b0,  4'hF, 64'h30,        4'hF, 64'h40,       3'd3, 4'h5, 1'b1, 64'd5);
    step("halt_ign",   1, 3'd1, 4'h6, 64'h99,        64'h0,         4'h9, 4'hF, 1'b0, 1'b0,  4'hF, 64'h30,        4'hF, 64'h40,       3'd3, 4'h5, 1'b1, 64'd5);
    step("halt_bub",   1, 3'd1, 4'h6, 64'h98,        64'h0,         4'h9, 4'hF, 1'b0, 1'b1,  4'hF, 64'h30,        4'hF, 64'h40,       3'd3, 4'h5, 1'b1, 64'd5);
    step("halt_stl",   1, 3'd4, 4'h6, 64'h97,        64'h0,         4'h9, 4'hF, 1'b1, 1'b0,  4'hF, 64'h30,        4'hF, 64'h40,       3'd3, 4'h5, 1'b1, 64'd5);

    @(negedge clk);
    #2;
    reset_now("rst_halt");
    release_reset();

    step("reload",     1, 3'd1, 4'h6, 64'h5555,      64'h0,         4'h5, 4'hF, 1'b0, 1'b0,  4'h5, 64'h5555,      4'hF, 64'h0,        3'd1, 4'h6, 1'b0, 64'd1);

    // Reset lands between clock edges while dstE=5 is live and still being driven.
    @(negedge clk);
    #2;
    reset_now("rst_mid");
    release_reset();

    step("hlt",        1, 3'd2, 4'h0, 64'h0,         64'h0,         4'hF, 4'hF, 1'b0, 1'b0,  4'hF, 64'h0,         4'hF, 64'h0,        3'd2, 4'h0, 1'b1, 64'd0);
    step("hlt_hold",   1, 3'd1, 4'h6, 64'h4242,      64'h0,         4'h3, 4'hF, 1'b0, 1'b0,  4'hF, 64'h0,         4'hF, 64'h0,        3'd2, 4'h0, 1'b1, 64'd0);

    repeat (3) @(negedge clk);
    chk("drain", "clk_q", 64'(clk_q.size()), 64'd0);
    chk("drain", "rst_q", 64'(rst_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Y86-64 pipeline writeback stage: the W pipeline register plus write-port driver for the register array.
- Latches Memory-stage results and drives the array's dstE/E and dstM/M write ports.
- Suppresses writes for bubbles and faulting instructions; resolves dstE/dstM collisions.
- Latches processor halt status.

Parameters:
- DATA_W, 64, width of valE/valM and register write data
- REG_W, 4, register ID width; all-ones (4'hF) is RNONE
- STAT_W, 3, status code width
- CNT_W, 64, retire counter width (optional feature only)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m_valid  in  1  M stage holds a real instruction
- m_stat  in  STAT_W  M status: 1 AOK, 2 HLT, 3 ADR, 4 INS
- m_icode  in  4  M instruction code
- m_valE  in  DATA_W  ALU result
- m_valM  in  DATA_W  memory read result
- m_dstE  in  REG_W  ALU-result destination
- m_dstM  in  REG_W  memory-result destination
- w_stall  in  1  hold W register contents
- w_bubble  in  1  load NOP into W register
- dstE  out  REG_W  register array E write index
- E  out  DATA_W  register array E write data
- dstM  out  REG_W  register array M write index
- M  out  DATA_W  register array M write data
- w_stat  out  STAT_W  status of instruction in W
- w_icode  out  4  icode in W (hazard unit)
- halted  out  1  processor stopped, sticky

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values:
  - W register holds a bubble: stat=AOK(1), icode=INOP(1), valid=0.
  - dstE=dstM=RNONE, E=M=0, w_stat=1, w_icode=1, halted=0.
  - FSM in RUN.
- Latency: 1 cycle. M-stage values present at edge N appear on the outputs after edge N.
- W register update per rising edge, priority highest first:
  1. reset
  2. halted: hold contents
  3. w_stall: hold contents
  4. w_bubble: load bubble
  5. otherwise: load m_* inputs
- Stall with bubble asserted together: stall wins.
- Write gating: the array writes on any change of index or data, so an inactive port must present RNONE.
  - dstE/dstM are the latched destinations only when valid=1 and stat==AOK.
  - Otherwise both are RNONE.
  - E/M always carry the latched valE/valM.
- Collision: when gated dstE==dstM and both are not RNONE, dstE is forced to RNONE so valM wins (popq %rsp semantics).
- Stall hold: dstE/dstM/E/M stay constant, so the array sees no new write.
- FSM states: RUN, HALTED.
  - RUN→HALTED at the edge that latches valid=1 with stat!=AOK (HLT, ADR or INS).
  - halted=1 from that edge onward.
  - That instruction performs no write; w_stat shows its code.
  - HALTED is sticky until rst_n asserts; m_*, w_stall and w_bubble are ignored.
  - dstE=dstM=RNONE and w_stat holds the fault code.
- Reset mid-operation: outputs clear asynchronously, with no partial write beyond what the array already captured.
- A bubble with stat!=AOK cannot occur (bubble stat is AOK). m_valid=0 with any stat is treated as a bubble and never halts.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- When defined:
  - Adds output retired[CNT_W-1:0], reset 0.
  - Increments by 1 at each edge that loads valid=1, stat==AOK into W (not stalled, not halted).
  - Wraps to 0 at all-ones.
  - HLT instruction not counted.
- When undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package y86_pkg:
  - stat codes SAOK=1, SHLT=2, SADR=3, SINS=4
  - RNONE=4'hF
  - icodes IHALT=0, INOP=1
  - struct for W register contents: valid, stat, icode, valE, valM, dstE, dstM
  - bubble constant
- Optional sub-module wb_retire_cnt for the counter.
- The W register and FSM stay in wb_stage.

Test Plan:
- Reset → dstE=dstM=4'hF, w_stat=1, halted=0. Then load m_valid=1, stat=1, dstE=3, valE=0x1234, dstM=F → one cycle later dstE=3, E=0x1234, dstM=F.
- Collision: dstE=4, valE=0x10, dstM=4, valM=0x99 → dstE=F, dstM=4, M=0x99.
- Stall held 3 cycles while m_* change → outputs unchanged. Bubble then → dstE=dstM=F, w_icode=1.
- stat=ADR(3), dstE=2 → dstE=F, w_stat=3, halted=1. Subsequent valid AOK inputs ignored; halted stays 1 until rst_n low.
- rst_n asserted mid-stream with dstE=5 driven → outputs clear immediately without waiting for clk.
- WB_RETIRE_CNT_EN: 5 AOK, 2 bubbles, 1 stalled edge, then HLT → retired=5.
